fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_fetch_pkg.sv | 15 +
 rtl/fetch_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath widths,
// the default reset fetch address and the fetch state encoding.
package riscv_fetch_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0004;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues word addresses to a one-cycle-latency
// instruction memory, presents the returned word to decode, replays the
// outstanding address while decode stalls, follows redirects, and stops
// fetching when an all-zero instruction word comes back.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_word,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   if_valid_o,
  output logic [ADDR_WIDTH-1:0]  if_pc_o,
  output logic [INSTR_WIDTH-1:0] if_instr_o,
  output logic                   halted_o,
  output logic [31:0]            fetch_count_o
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           count_q, count_d;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic                  word_zero;
  logic                  running;
  logic                  deliver;
  logic                  unused_target_bits;

  // Sequential PC increment wraps naturally at the top of the address space.
  assign pc_plus4           = fetch_pc_q + 32'd4;
  assign target_aligned     = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
  assign unused_target_bits = |redirect_target[1:0];
  assign word_zero          = (imem_word == '0);
  assign running            = (state_q == RUN);

  // While decode stalls on a live response, re-issue that response's
  // address so the memory keeps returning the same word.
  always_comb begin
    imem_addr = fetch_pc_q;
    if (stall_i && running && resp_valid_q) begin
      imem_addr = resp_pc_q;
    end
  end

  // Decode-facing outputs are views of the response register and memory data.
  always_comb begin
    if_pc_o       = resp_pc_q;
    if_instr_o    = imem_word;
    if_valid_o    = resp_valid_q && running && !word_zero;
    halted_o      = (state_q == HALT);
    fetch_count_o = count_q;
    deliver       = if_valid_o && !stall_i && !redirect_i;
  end

  // Next-state selection: redirect beats everything, HALT holds, a zero
  // word halts even under stall, otherwise advance unless stalled.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    count_d      = count_q;

    if (deliver) begin
      count_d = count_q + 32'd1;
    end

    if (redirect_i) begin
      state_d      = RUN;
      fetch_pc_d   = target_aligned;
      resp_valid_d = 1'b0;
    end else if (running) begin
      if (resp_valid_q && word_zero) begin
        state_d      = HALT;
        resp_valid_d = 1'b0;
      end else if (!stall_i) begin
        resp_pc_d    = fetch_pc_q;
        resp_valid_d = 1'b1;
        fetch_pc_d   = pc_plus4;
      end
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      count_q      <= count_d;
    end
  end

endmodule
